// File: rtl/gps_sweep_ctrl.sv
// Acquisition-test sequencer: steps gps_gen_core through a Doppler x C/A-phase grid,
// applying each new configuration only on a code-epoch boundary.
//
// state | meaning
// IDLE  | core disabled, waiting for a sweep_en_in rising edge
// ARM   | core enabled, waiting for the first epoch to align dwell counting
// DWELL | counting epochs per bin, advancing Doppler / phase on bin completion
// DONE  | single sweep finished, waiting for sweep_en_in to drop
module gps_sweep_ctrl #(
  parameter int DOPPLER_W = 8,
  parameter int PHASE_W   = 16,
  parameter int DWELL_W   = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in_n,
  input  logic                 sweep_en_in,
  input  logic                 mode_in,
  input  logic [DOPPLER_W-1:0] dop_start_in,
  input  logic [DOPPLER_W-1:0] dop_stop_in,
  input  logic [DOPPLER_W-1:0] dop_step_in,
  input  logic [DWELL_W-1:0]   dwell_in,
  input  logic [DWELL_W-1:0]   passes_in,
  input  logic [PHASE_W-1:0]   phase_base_in,
  input  logic [PHASE_W-1:0]   phase_step_in,
  input  logic                 epoch_in,
  output logic                 core_ena_out,
  output logic [DOPPLER_W-1:0] doppler_out,
  output logic [PHASE_W-1:0]   ca_phase_out,
  output logic                 cfg_update_out,
  output logic                 busy_out,
  output logic                 done_out
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_DWELL, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 epoch_q, sweep_en_q;
  logic [DOPPLER_W-1:0] dop_q, dop_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 cfg_q, cfg_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0]   pass_cnt_q, pass_cnt_d;

  logic [DOPPLER_W-1:0] start_q, start_d;
  logic [DOPPLER_W-1:0] stop_q, stop_d;
  logic [DOPPLER_W-1:0] step_q, step_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   passes_q, passes_d;
  logic [PHASE_W-1:0]   base_q, base_d;
  logic [PHASE_W-1:0]   pstep_q, pstep_d;
  logic                 mode_q, mode_d;

  logic                   ep;
  logic                   sweep_rise;
  logic signed [DOPPLER_W+1:0] nxt_dop;
  logic signed [DOPPLER_W+1:0] stop_ext;
  logic                   in_range;
  logic                   bin_last;
  logic [DWELL_W:0]       pass_inc;
  logic                   pass_last;

  assign ep         = epoch_in & ~epoch_q;
  assign sweep_rise = sweep_en_in & ~sweep_en_q;

  // Two guard bits keep start+step from wrapping back into range (e.g. 127+255).
  assign nxt_dop  = $signed({{2{dop_q[DOPPLER_W-1]}}, dop_q}) + $signed({2'b00, step_q});
  assign stop_ext = $signed({{2{stop_q[DOPPLER_W-1]}}, stop_q});
  assign in_range = (nxt_dop <= stop_ext);

  assign bin_last  = (dwell_cnt_q == (dwell_q - DWELL_W'(1)));
  assign pass_inc  = {1'b0, pass_cnt_q} + (DWELL_W+1)'(1);
  assign pass_last = (pass_inc == {1'b0, passes_q});

  always_comb begin
    state_d     = state_q;
    dop_d       = dop_q;
    phase_d     = phase_q;
    cfg_d       = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    start_d     = start_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    passes_d    = passes_q;
    base_d      = base_q;
    pstep_d     = pstep_q;
    mode_d      = mode_q;

    unique case (state_q)
      S_IDLE: begin
        if (sweep_rise) begin
          start_d  = dop_start_in;
          stop_d   = dop_stop_in;
          step_d   = (dop_step_in == '0) ? DOPPLER_W'(1) : dop_step_in;
          dwell_d  = (dwell_in == '0) ? DWELL_W'(1) : dwell_in;
          passes_d = (passes_in == '0) ? DWELL_W'(1) : passes_in;
          base_d   = phase_base_in;
          pstep_d  = phase_step_in;
          mode_d   = mode_in;
          dop_d    = dop_start_in;
          phase_d  = phase_base_in;
          cfg_d    = 1'b1;
          state_d  = S_ARM;
        end
      end

      S_ARM: begin
        if (!sweep_en_in) begin
          state_d = S_IDLE;
        end else if (ep) begin
          dwell_cnt_d = '0;
          pass_cnt_d  = '0;
          state_d     = S_DWELL;
        end
      end

      S_DWELL: begin
        if (!sweep_en_in) begin
          state_d = S_IDLE;
        end else if (ep) begin
          if (!bin_last) begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end else if (in_range) begin
            dop_d       = nxt_dop[DOPPLER_W-1:0];
            dwell_cnt_d = '0;
            cfg_d       = 1'b1;
          end else if (pass_last && !mode_q) begin
            // Final pass of a single sweep: leave the last bin on the core.
            dwell_cnt_d = '0;
            pass_cnt_d  = pass_inc[DWELL_W-1:0];
            state_d     = S_DONE;
          end else if (pass_last) begin
            dop_d       = start_q;
            phase_d     = base_q;
            pass_cnt_d  = '0;
            dwell_cnt_d = '0;
            cfg_d       = 1'b1;
          end else begin
            dop_d       = start_q;
            phase_d     = phase_q + pstep_q;
            pass_cnt_d  = pass_inc[DWELL_W-1:0];
            dwell_cnt_d = '0;
            cfg_d       = 1'b1;
          end
        end
      end

      S_DONE: begin
        if (!sweep_en_in) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q     <= S_IDLE;
      epoch_q     <= 1'b0;
      sweep_en_q  <= 1'b0;
      dop_q       <= '0;
      phase_q     <= '0;
      cfg_q       <= 1'b0;
      dwell_cnt_q <= '0;
      pass_cnt_q  <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      passes_q    <= '0;
      base_q      <= '0;
      pstep_q     <= '0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      epoch_q     <= epoch_in;
      sweep_en_q  <= sweep_en_in;
      dop_q       <= dop_d;
      phase_q     <= phase_d;
      cfg_q       <= cfg_d;
      dwell_cnt_q <= dwell_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      passes_q    <= passes_d;
      base_q      <= base_d;
      pstep_q     <= pstep_d;
      mode_q      <= mode_d;
    end
  end

  assign core_ena_out   = (state_q == S_ARM) || (state_q == S_DWELL);
  assign busy_out       = (state_q == S_ARM) || (state_q == S_DWELL);
  assign done_out       = (state_q == S_DONE);
  assign doppler_out    = dop_q;
  assign ca_phase_out   = phase_q;
  assign cfg_update_out = cfg_q;

endmodule

// File: tb/tb_gps_sweep_ctrl.sv
// Directed bench for gps_sweep_ctrl: hand-computed Doppler/phase sequences
// checked with immediate assertions after each code epoch.
module tb_gps_sweep_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in_n;
  logic        sweep_en_in;
  logic        mode_in;
  logic [7:0]  dop_start_in, dop_stop_in, dop_step_in;
  logic [7:0]  dwell_in, passes_in;
  logic [15:0] phase_base_in, phase_step_in;
  logic        epoch_in;
  logic        core_ena_out;
  logic [7:0]  doppler_out;
  logic [15:0] ca_phase_out;
  logic        cfg_update_out;
  logic        busy_out;
  logic        done_out;

  int vectors = 0;
  int miscompares = 0;
  int cfg_cnt = 0;

  logic [7:0]  t4_dop [4];
  logic [15:0] t4_ph  [4];

  always #5 clk_in = ~clk_in;

  gps_sweep_ctrl #(.DOPPLER_W(8), .PHASE_W(16), .DWELL_W(8)) dut (
    .clk_in        (clk_in),
    .rst_in_n      (rst_in_n),
    .sweep_en_in   (sweep_en_in),
    .mode_in       (mode_in),
    .dop_start_in  (dop_start_in),
    .dop_stop_in   (dop_stop_in),
    .dop_step_in   (dop_step_in),
    .dwell_in      (dwell_in),
    .passes_in     (passes_in),
    .phase_base_in (phase_base_in),
    .phase_step_in (phase_step_in),
    .epoch_in      (epoch_in),
    .core_ena_out  (core_ena_out),
    .doppler_out   (doppler_out),
    .ca_phase_out  (ca_phase_out),
    .cfg_update_out(cfg_update_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_cfg(input logic [7:0] st, input logic [7:0] sp, input logic [7:0] stp,
                         input logic [7:0] dw, input logic [7:0] ps,
                         input logic [15:0] base, input logic [15:0] pstep, input logic md);
    dop_start_in  = st;
    dop_stop_in   = sp;
    dop_step_in   = stp;
    dwell_in      = dw;
    passes_in     = ps;
    phase_base_in = base;
    phase_step_in = pstep;
    mode_in       = md;
  endtask

  task automatic start_sweep();
    @(negedge clk_in);
    sweep_en_in = 1'b1;
    @(negedge clk_in);
    cfg_cnt = int'(cfg_update_out);
  endtask

  task automatic stop_sweep();
    @(negedge clk_in);
    sweep_en_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic ep();
    @(negedge clk_in);
    epoch_in = 1'b1;
    @(negedge clk_in);
    epoch_in = 1'b0;
    cfg_cnt += int'(cfg_update_out);
  endtask

  initial begin
    t4_dop = '{8'd1, 8'd0, 8'd1, 8'd0};
    t4_ph  = '{16'd0, 16'd5, 16'd5, 16'd0};
    rst_in_n    = 1'b0;
    sweep_en_in = 1'b0;
    epoch_in    = 1'b0;
    set_cfg(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 16'd0, 1'b0);
    repeat (2) @(negedge clk_in);
    chk("rst ena", 32'(core_ena_out), 32'd0);
    chk("rst dop", 32'(doppler_out), 32'd0);
    chk("rst phase", 32'(ca_phase_out), 32'd0);
    chk("rst cfg", 32'(cfg_update_out), 32'd0);
    chk("rst busy", 32'(busy_out), 32'd0);
    chk("rst done", 32'(done_out), 32'd0);
    rst_in_n = 1'b1;

    // 1: -2..2 step 2, one pass
    set_cfg(8'hFE, 8'd2, 8'd2, 8'd1, 8'd1, 16'd100, 16'd0, 1'b0);
    start_sweep();
    chk("t1 start dop", 32'(doppler_out), 32'h00FE);
    chk("t1 start phase", 32'(ca_phase_out), 32'd100);
    chk("t1 start cfg", 32'(cfg_update_out), 32'd1);
    chk("t1 start busy", 32'(busy_out), 32'd1);
    ep();
    chk("t1 ep1 dop", 32'(doppler_out), 32'h00FE);
    chk("t1 ep1 cfg", 32'(cfg_update_out), 32'd0);
    ep();
    chk("t1 ep2 dop", 32'(doppler_out), 32'd0);
    ep();
    chk("t1 ep3 dop", 32'(doppler_out), 32'd2);
    ep();
    chk("t1 ep4 done", 32'(done_out), 32'd1);
    chk("t1 ep4 ena", 32'(core_ena_out), 32'd0);
    chk("t1 ep4 dop", 32'(doppler_out), 32'd2);
    chk("t1 cfg count", 32'(cfg_cnt), 32'd3);
    stop_sweep();
    chk("t1 idle done", 32'(done_out), 32'd0);

    // 2: dwell of 3 epochs per bin
    set_cfg(8'hFE, 8'd2, 8'd2, 8'd3, 8'd1, 16'd100, 16'd0, 1'b0);
    start_sweep();
    repeat (3) ep();
    chk("t2 ep3 dop", 32'(doppler_out), 32'h00FE);
    ep();
    chk("t2 ep4 dop", 32'(doppler_out), 32'd0);
    repeat (2) ep();
    chk("t2 ep6 dop", 32'(doppler_out), 32'd0);
    ep();
    chk("t2 ep7 dop", 32'(doppler_out), 32'd2);
    repeat (2) ep();
    chk("t2 ep9 done", 32'(done_out), 32'd0);
    ep();
    chk("t2 ep10 done", 32'(done_out), 32'd1);
    stop_sweep();

    // 3: phase wraps modulo 2^16
    set_cfg(8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 16'd65530, 16'd10, 1'b0);
    start_sweep();
    chk("t3 start phase", 32'(ca_phase_out), 32'd65530);
    repeat (2) ep();
    chk("t3 ep2 phase", 32'(ca_phase_out), 32'd4);
    chk("t3 ep2 dop", 32'(doppler_out), 32'd0);
    chk("t3 ep2 done", 32'(done_out), 32'd0);
    ep();
    chk("t3 ep3 done", 32'(done_out), 32'd1);
    stop_sweep();

    // 4: continuous mode loops back to (0,0)
    set_cfg(8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 16'd0, 16'd5, 1'b1);
    start_sweep();
    ep();
    for (int i = 0; i < 4; i++) begin
      ep();
      chk($sformatf("t4 step%0d dop", i), 32'(doppler_out), 32'(t4_dop[i]));
      chk($sformatf("t4 step%0d phase", i), 32'(ca_phase_out), 32'(t4_ph[i]));
      chk($sformatf("t4 step%0d done", i), 32'(done_out), 32'd0);
    end
    ep();
    chk("t4 wrap2 dop", 32'(doppler_out), 32'd1);
    stop_sweep();

    // 5: abort mid-dwell and restart with new start value
    set_cfg(8'd0, 8'd10, 8'd1, 8'd1, 8'd1, 16'd0, 16'd0, 1'b0);
    start_sweep();
    repeat (2) ep();
    chk("t5 ep2 dop", 32'(doppler_out), 32'd1);
    dop_start_in = 8'd4;
    ep();
    chk("t5 shadow dop", 32'(doppler_out), 32'd2);
    @(negedge clk_in);
    sweep_en_in = 1'b0;
    @(negedge clk_in);
    chk("t5 abort ena", 32'(core_ena_out), 32'd0);
    chk("t5 abort busy", 32'(busy_out), 32'd0);
    chk("t5 abort dop", 32'(doppler_out), 32'd2);
    chk("t5 abort done", 32'(done_out), 32'd0);
    @(negedge clk_in);
    sweep_en_in = 1'b1;
    @(negedge clk_in);
    chk("t5 restart dop", 32'(doppler_out), 32'd4);
    chk("t5 restart cfg", 32'(cfg_update_out), 32'd1);
    stop_sweep();

    // 6a: zero step/dwell/passes act as 1, start edge coincident with epoch
    set_cfg(8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 16'd0, 16'd0, 1'b0);
    @(negedge clk_in);
    sweep_en_in = 1'b1;
    epoch_in    = 1'b1;
    @(negedge clk_in);
    epoch_in = 1'b0;
    chk("t6a arm busy", 32'(busy_out), 32'd1);
    ep();
    chk("t6a ep1 dop", 32'(doppler_out), 32'd0);
    chk("t6a ep1 cfg", 32'(cfg_update_out), 32'd0);
    ep();
    chk("t6a ep2 dop", 32'(doppler_out), 32'd1);
    ep();
    chk("t6a ep3 done", 32'(done_out), 32'd1);
    stop_sweep();

    // 6b: 127 + 255 must not wrap back into range
    set_cfg(8'd127, 8'd127, 8'd255, 8'd1, 8'd1, 16'd0, 16'd0, 1'b0);
    start_sweep();
    repeat (2) ep();
    chk("t6b done", 32'(done_out), 32'd1);
    chk("t6b dop", 32'(doppler_out), 32'd127);
    stop_sweep();

    // 6c: stop below start gives one bin
    set_cfg(8'd3, 8'hFB, 8'd1, 8'd1, 8'd1, 16'd0, 16'd0, 1'b0);
    start_sweep();
    repeat (2) ep();
    chk("t6c done", 32'(done_out), 32'd1);
    chk("t6c dop", 32'(doppler_out), 32'd3);
    stop_sweep();

    // 6d: long epoch level counts once, then async reset mid-sweep
    set_cfg(8'd0, 8'd10, 8'd1, 8'd1, 8'd1, 16'd7, 16'd0, 1'b0);
    start_sweep();
    ep();
    @(negedge clk_in);
    epoch_in = 1'b1;
    repeat (4) @(negedge clk_in);
    epoch_in = 1'b0;
    chk("t6d held dop", 32'(doppler_out), 32'd1);
    #2 rst_in_n = 1'b0;
    #1;
    chk("t6d rst ena", 32'(core_ena_out), 32'd0);
    chk("t6d rst dop", 32'(doppler_out), 32'd0);
    chk("t6d rst phase", 32'(ca_phase_out), 32'd0);
    chk("t6d rst busy", 32'(busy_out), 32'd0);
    sweep_en_in = 1'b0;
    @(negedge clk_in);
    rst_in_n = 1'b1;
    repeat (2) @(negedge clk_in);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gps_sweep_ctrl.md
Name: gps_sweep_ctrl

Overview:
Acquisition-test sequencer that drives the configuration of gps_gen_core through a 2-D search grid of Doppler bins and C/A code phase offsets. It sits between the register bank and the core, taking over the core's enable, doppler and ca_phase inputs. It changes configuration only on code-epoch boundaries, which it detects from the core's start pulse, so the core never sees a mid-epoch update. The sweep supports a single-shot mode and a continuous mode.

Parameters:
DOPPLER_W, 8, width of the signed (two's complement) Doppler word
PHASE_W, 16, width of the C/A phase word; phase arithmetic is modulo 2^PHASE_W
DWELL_W, 8, width of the dwell and pass counters

Ports:
clk_in  input  1  system clock
rst_in_n  input  1  asynchronous active-low reset
sweep_en_in  input  1  level; 0->1 starts a sweep; low at any time aborts it
mode_in  input  1  0 = single sweep, 1 = continuous loop
dop_start_in  input  DOPPLER_W  signed first Doppler bin
dop_stop_in  input  DOPPLER_W  signed last allowed Doppler bin
dop_step_in  input  DOPPLER_W  unsigned bin increment; 0 is treated as 1
dwell_in  input  DWELL_W  epochs per bin; 0 is treated as 1
passes_in  input  DWELL_W  Doppler passes per sweep; 0 is treated as 1
phase_base_in  input  PHASE_W  C/A phase for the first pass
phase_step_in  input  PHASE_W  phase increment applied per pass
epoch_in  input  1  core start pulse (code epoch), synchronous to clk_in
core_ena_out  output  1  enable to the core
doppler_out  output  DOPPLER_W  Doppler word to the core
ca_phase_out  output  PHASE_W  C/A phase word to the core
cfg_update_out  output  1  one-cycle pulse whenever doppler_out or ca_phase_out is loaded
busy_out  output  1  high in ARM or DWELL
done_out  output  1  high in DONE

Behaviour:
- Reset values of all outputs are 0. The FSM resets to IDLE and all counters reset to 0.
- The clock and reset are fixed as stated: single clock clk_in; reset rst_in_n is asynchronous and active-low.
- Epoch edge detection:
  - ep = epoch_in & ~epoch_q, where epoch_q is epoch_in registered.
  - A level held high for several cycles counts as one epoch.
- States are IDLE, ARM, DWELL and DONE.
- IDLE:
  - core_ena_out = 0.
  - On a rising edge of sweep_en_in, latch every *_in config input into shadow registers. Changes to config inputs after this point are ignored until the next start.
  - In the same edge, load doppler_out = dop_start and ca_phase_out = phase_base, pulse cfg_update_out, and go to ARM.
- ARM:
  - core_ena_out = 1 and busy_out = 1.
  - The first ep clears the dwell and pass counters and moves to DWELL. No config change happens on this epoch.
- DWELL:
  - On each ep, increment dwell_cnt.
  - When ep arrives with dwell_cnt == dwell-1, the bin is complete:
    - Compute nxt = doppler_out + step in DOPPLER_W+2 signed bits, with no wrap.
    - If nxt <= stop (signed): doppler_out <= nxt.
    - Otherwise the pass is complete: doppler_out <= start, ca_phase_out <= ca_phase_out + phase_step (mod 2^PHASE_W), and pass_cnt increments.
    - In both cases clear dwell_cnt and pulse cfg_update_out.
  - Pass handling:
    - When a completing pass brings pass_cnt to passes and mode = 0, go to DONE. doppler_out and ca_phase_out hold their last bin values and cfg_update_out does not pulse.
    - When mode = 1, clear pass_cnt and reload ca_phase_out <= phase_base instead of adding phase_step.
- DONE:
  - core_ena_out = 0, busy_out = 0, done_out = 1.
  - Stays in DONE until sweep_en_in is low, then goes to IDLE.
- Latency: new config is visible on the clock edge that first samples epoch_in high. cfg_update_out is high for exactly that cycle.
- Abort: sweep_en_in low in ARM or DWELL forces IDLE on the next edge. core_ena_out and busy_out drop, doppler_out and ca_phase_out hold, and done_out stays 0.
- Boundary cases:
  - stop < start gives a one-bin pass (start only).
  - start = 127 with step = 255 must not overflow into a false in-range value.
  - A sweep_en_in edge and ep in the same cycle in IDLE: the start takes priority and the ep is ignored.
  - An asynchronous reset mid-sweep returns immediately to the reset values.

Test Plan:
1. start=0xFE(-2), stop=2, step=2, dwell=1, passes=1, base=100, pstep=0, mode=0:
   - doppler_out = -2 at start; 0 after epoch 2; 2 after epoch 3.
   - Epoch 4 gives DONE with doppler_out = 2 and core_ena_out = 0.
   - cfg_update_out pulses 3 times in total.
2. Same config with dwell=3: doppler_out changes only on epochs 4 and 7; DONE on epoch 10.
3. start=0, stop=0, passes=2, base=65530, pstep=10: ca_phase_out = 65530, then 4 after epoch 2 (wrap); DONE on epoch 3.
4. mode=1, start=0, stop=1, step=1, passes=2, pstep=5, base=0: sequence (0,0), (1,0), (0,5), (1,5), then back to (0,0); done_out is never asserted.
5. Deassert sweep_en_in mid-DWELL:
   - core_ena_out and busy_out drop 1 cycle later.
   - Changing dop_start to 4 and re-raising sweep_en_in gives doppler_out = 4.
   - Changing dop_start mid-sweep without an abort has no effect.
6. Overflow and degenerate cases:
   - step=0, dwell=0, passes=0 behave as 1/1/1.
   - start=127, stop=127, step=255 gives a single bin, then DONE.
   - stop=-5 with start=3 gives a single bin.
   - Holding epoch_in high for 4 cycles counts as one epoch.
